// File: rtl/bilinear_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bilinear_fetch_ctrl
//  Description : Upstream feeder for the bilinear interpolation pipeline.
//                Walks the destination raster of a downscale job, maps each
//                destination pixel to a Q8.8 source coordinate, fetches the
//                four neighbouring source pixels from a synchronous RAM and
//                emits one sample (4 pixels + Q8.8 weights + start strobe).
//
//  Ports       : clk, rst_n          clock, asynchronous active-low reset
//                i_start             job start pulse (accepted in IDLE only)
//                i_src_w/i_src_h     source dimensions   (latched at start)
//                i_dst_w/i_dst_h     destination dims    (latched at start)
//                i_step              Q8.8 source step    (latched at start)
//                o_rd_en/o_rd_addr   source RAM read strobe / address
//                i_rd_data           RAM data, valid the cycle after o_rd_en
//                o_p1..o_p4          neighbours (x0,y0) (x1,y0) (x0,y1) (x1,y1)
//                o_wx/o_wy           Q8.8 weights {8'h00, frac}
//                o_start             one-cycle sample strobe
//                o_busy / o_done     job in progress / job complete pulse
//
//  Revision    : 1.0  initial release
// ============================================================================
module bilinear_fetch_ctrl #(
    parameter int DIM_W  = 10,
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [DIM_W-1:0]  i_src_w,
    input  logic [DIM_W-1:0]  i_src_h,
    input  logic [DIM_W-1:0]  i_dst_w,
    input  logic [DIM_W-1:0]  i_dst_h,
    input  logic [15:0]       i_step,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [7:0]        i_rd_data,
    output logic [7:0]        o_p1,
    output logic [7:0]        o_p2,
    output logic [7:0]        o_p3,
    output logic [7:0]        o_p4,
    output logic [15:0]       o_wx,
    output logic [15:0]       o_wy,
    output logic              o_start,
    output logic              o_busy,
    output logic              o_done
);

    // Accumulators carry 8 fractional bits; the integer part is wide enough
    // for (dst-1)*step without wrapping.
    localparam int c_ACC_W = DIM_W + 16;
    localparam int c_INT_W = c_ACC_W - 8;

    localparam logic [DIM_W-1:0] c_DIM_ONE = DIM_W'(1);
    localparam logic [c_INT_W:0] c_INT_ONE = (c_INT_W + 1)'(1);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_CALC = 3'd1;
    localparam logic [2:0] c_ST_RD0  = 3'd2;
    localparam logic [2:0] c_ST_RD1  = 3'd3;
    localparam logic [2:0] c_ST_RD2  = 3'd4;
    localparam logic [2:0] c_ST_RD3  = 3'd5;
    localparam logic [2:0] c_ST_CAP  = 3'd6;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;

    // Latched job configuration
    logic [DIM_W-1:0]   r_src_w;
    logic [DIM_W-1:0]   r_src_h;
    logic [DIM_W-1:0]   r_dst_w;
    logic [DIM_W-1:0]   r_dst_h;
    logic [15:0]        r_step;

    // Raster position and source-coordinate accumulators
    logic [DIM_W-1:0]   r_dx;
    logic [DIM_W-1:0]   r_dy;
    logic [c_ACC_W-1:0] r_acc_x;
    logic [c_ACC_W-1:0] r_acc_y;

    // Per-pixel fetch context captured in CALC
    logic [DIM_W-1:0]   r_x0;
    logic [DIM_W-1:0]   r_x1;
    logic [ADDR_W-1:0]  r_base0;
    logic [ADDR_W-1:0]  r_base1;

    // Neighbours collected while the reads stream back
    logic [7:0]         r_p1;
    logic [7:0]         r_p2;
    logic [7:0]         r_p3;

    // Next values of the registered strobes
    logic               w_rd_en_nxt;
    logic               w_start_nxt;
    logic               w_done_nxt;
    logic               w_busy_nxt;

    logic               w_zero_job;
    logic               w_row_end;
    logic               w_last;

    logic [c_INT_W:0]   w_xi;
    logic [c_INT_W:0]   w_yi;
    logic [c_INT_W:0]   w_xi_p1;
    logic [c_INT_W:0]   w_yi_p1;
    logic [DIM_W-1:0]   w_lim_x;
    logic [DIM_W-1:0]   w_lim_y;
    logic [DIM_W-1:0]   w_x0;
    logic [DIM_W-1:0]   w_x1;
    logic [DIM_W-1:0]   w_y0;
    logic [DIM_W-1:0]   w_y1;
    logic [ADDR_W-1:0]  w_base0;
    logic [ADDR_W-1:0]  w_base1;

    // Edge replicate: coordinates past the right/bottom edge map to the edge.
    function automatic logic [DIM_W-1:0] clamp_coord(
        input logic [c_INT_W:0] v,
        input logic [DIM_W-1:0] lim
    );
        clamp_coord = (v > (c_INT_W + 1)'(lim)) ? lim : v[DIM_W-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Coordinate mapping (consumed in CALC)
    // ------------------------------------------------------------------
    assign w_xi    = {1'b0, r_acc_x[c_ACC_W-1:8]};
    assign w_yi    = {1'b0, r_acc_y[c_ACC_W-1:8]};
    assign w_xi_p1 = w_xi + c_INT_ONE;
    assign w_yi_p1 = w_yi + c_INT_ONE;
    assign w_lim_x = r_src_w - c_DIM_ONE;
    assign w_lim_y = r_src_h - c_DIM_ONE;
    assign w_x0    = clamp_coord(w_xi,    w_lim_x);
    assign w_x1    = clamp_coord(w_xi_p1, w_lim_x);
    assign w_y0    = clamp_coord(w_yi,    w_lim_y);
    assign w_y1    = clamp_coord(w_yi_p1, w_lim_y);

    // ADDR_W >= 2*DIM_W, so the row-base products never truncate.
    assign w_base0 = ADDR_W'(w_y0) * ADDR_W'(r_src_w);
    assign w_base1 = ADDR_W'(w_y1) * ADDR_W'(r_src_w);

    assign w_zero_job = (i_dst_w == '0) || (i_dst_h == '0);
    assign w_row_end  = (r_dx == r_dst_w - c_DIM_ONE);
    assign w_last     = w_row_end && (r_dy == r_dst_h - c_DIM_ONE);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: if (i_start && !w_zero_job) w_next_state = c_ST_CALC;
            c_ST_CALC: w_next_state = c_ST_RD0;
            c_ST_RD0:  w_next_state = c_ST_RD1;
            c_ST_RD1:  w_next_state = c_ST_RD2;
            c_ST_RD2:  w_next_state = c_ST_RD3;
            c_ST_RD3:  w_next_state = c_ST_CAP;
            c_ST_CAP:  w_next_state = w_last ? c_ST_IDLE : c_ST_CALC;
            default:   w_next_state = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic (next values of the registered strobes)
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_en_nxt = 1'b0;
        w_start_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        w_busy_nxt  = 1'b1;
        case (r_state)
            c_ST_IDLE: begin
                // busy covers the zero-size job's done cycle as well
                w_busy_nxt = i_start;
                w_done_nxt = i_start && w_zero_job;
            end
            c_ST_CALC, c_ST_RD0, c_ST_RD1, c_ST_RD2: begin
                w_rd_en_nxt = 1'b1;
            end
            c_ST_CAP: begin
                w_start_nxt = 1'b1;
                w_done_nxt  = w_last;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src_w   <= '0;
            r_src_h   <= '0;
            r_dst_w   <= '0;
            r_dst_h   <= '0;
            r_step    <= '0;
            r_dx      <= '0;
            r_dy      <= '0;
            r_acc_x   <= '0;
            r_acc_y   <= '0;
            r_x0      <= '0;
            r_x1      <= '0;
            r_base0   <= '0;
            r_base1   <= '0;
            r_p1      <= '0;
            r_p2      <= '0;
            r_p3      <= '0;
            o_rd_en   <= 1'b0;
            o_rd_addr <= '0;
            o_p1      <= '0;
            o_p2      <= '0;
            o_p3      <= '0;
            o_p4      <= '0;
            o_wx      <= '0;
            o_wy      <= '0;
            o_start   <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            o_rd_en <= w_rd_en_nxt;
            o_start <= w_start_nxt;
            o_done  <= w_done_nxt;
            o_busy  <= w_busy_nxt;

            // The address is registered one state ahead so that it is
            // presented together with o_rd_en in RD0..RD3.
            case (r_state)
                c_ST_IDLE: begin
                    if (i_start) begin
                        r_src_w <= i_src_w;
                        r_src_h <= i_src_h;
                        r_dst_w <= i_dst_w;
                        r_dst_h <= i_dst_h;
                        r_step  <= i_step;
                        r_dx    <= '0;
                        r_dy    <= '0;
                        r_acc_x <= '0;
                        r_acc_y <= '0;
                    end
                end
                c_ST_CALC: begin
                    r_x0      <= w_x0;
                    r_x1      <= w_x1;
                    r_base0   <= w_base0;
                    r_base1   <= w_base1;
                    o_rd_addr <= w_base0 + ADDR_W'(w_x0);
                end
                c_ST_RD0: begin
                    o_rd_addr <= r_base0 + ADDR_W'(r_x1);
                end
                c_ST_RD1: begin
                    r_p1      <= i_rd_data;
                    o_rd_addr <= r_base1 + ADDR_W'(r_x0);
                end
                c_ST_RD2: begin
                    r_p2      <= i_rd_data;
                    o_rd_addr <= r_base1 + ADDR_W'(r_x1);
                end
                c_ST_RD3: begin
                    r_p3 <= i_rd_data;
                end
                c_ST_CAP: begin
                    // Accumulators are untouched since CALC, so their
                    // fractions still belong to the pixel being emitted.
                    o_p1 <= r_p1;
                    o_p2 <= r_p2;
                    o_p3 <= r_p3;
                    o_p4 <= i_rd_data;
                    o_wx <= {8'h00, r_acc_x[7:0]};
                    o_wy <= {8'h00, r_acc_y[7:0]};
                    if (w_row_end) begin
                        r_dx    <= '0;
                        r_acc_x <= '0;
                        r_dy    <= r_dy + c_DIM_ONE;
                        r_acc_y <= r_acc_y + c_ACC_W'(r_step);
                    end else begin
                        r_dx    <= r_dx + c_DIM_ONE;
                        r_acc_x <= r_acc_x + c_ACC_W'(r_step);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bilinear_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bilinear_fetch_ctrl
//  Description : Directed self-checking bench for bilinear_fetch_ctrl with a
//                synchronous source RAM model holding mem[a] = a[7:0].
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bilinear_fetch_ctrl;

    localparam int DIM_W  = 10;
    localparam int ADDR_W = 20;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_start;
    logic [DIM_W-1:0]  i_src_w;
    logic [DIM_W-1:0]  i_src_h;
    logic [DIM_W-1:0]  i_dst_w;
    logic [DIM_W-1:0]  i_dst_h;
    logic [15:0]       i_step;
    logic              o_rd_en;
    logic [ADDR_W-1:0] o_rd_addr;
    logic [7:0]        r_rd_data = 8'h00;
    logic [7:0]        o_p1;
    logic [7:0]        o_p2;
    logic [7:0]        o_p3;
    logic [7:0]        o_p4;
    logic [15:0]       o_wx;
    logic [15:0]       o_wy;
    logic              o_start;
    logic              o_busy;
    logic              o_done;

    always #5 clk = ~clk;

    // Synchronous source RAM, contents mem[a] = a[7:0]
    always @(posedge clk) begin
        if (o_rd_en) r_rd_data <= o_rd_addr[7:0];
    end

    bilinear_fetch_ctrl #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (i_start),
        .i_src_w   (i_src_w),
        .i_src_h   (i_src_h),
        .i_dst_w   (i_dst_w),
        .i_dst_h   (i_dst_h),
        .i_step    (i_step),
        .o_rd_en   (o_rd_en),
        .o_rd_addr (o_rd_addr),
        .i_rd_data (r_rd_data),
        .o_p1      (o_p1),
        .o_p2      (o_p2),
        .o_p3      (o_p3),
        .o_p4      (o_p4),
        .o_wx      (o_wx),
        .o_wy      (o_wy),
        .o_start   (o_start),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] smp_q[$];
    logic [31:0] wgt_q[$];
    logic [31:0] addr_q[$];
    logic [31:0] exp_smp_q[$];
    logic [31:0] exp_wgt_q[$];
    logic [31:0] exp_addr_q[$];
    int          done_cnt;
    int          done_cyc;
    bit          got_done;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
        q_at = (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic clear_logs();
        smp_q.delete(); wgt_q.delete(); addr_q.delete();
        exp_smp_q.delete(); exp_wgt_q.delete(); exp_addr_q.delete();
        done_cnt = 0;
    endtask

    task automatic chk_zero(input string pfx);
        check({pfx, "_p"},    {o_p1, o_p2, o_p3, o_p4}, 32'd0);
        check({pfx, "_w"},    {o_wx, o_wy}, 32'd0);
        check({pfx, "_addr"}, 32'(o_rd_addr), 32'd0);
        check({pfx, "_ctl"},  {28'd0, o_rd_en, o_start, o_busy, o_done}, 32'd0);
    endtask

    // Starts a job at the current negedge and logs outputs until o_done.
    // Returns on the negedge where o_done is seen so that a following call
    // lands its start in the o_done cycle. inj>0 pulses a bogus start then.
    task automatic run_job(input logic [DIM_W-1:0] sw, input logic [DIM_W-1:0] sh,
                           input logic [DIM_W-1:0] dw, input logic [DIM_W-1:0] dh,
                           input logic [15:0] st, input int max_cyc, input int inj);
        int cyc;
        i_src_w = sw; i_src_h = sh; i_dst_w = dw; i_dst_h = dh; i_step = st;
        i_start = 1'b1;
        @(negedge clk);
        i_start  = 1'b0;
        cyc      = 1;
        got_done = 1'b0;
        done_cyc = -1;
        while (!got_done && cyc <= max_cyc) begin
            if (o_start) begin
                smp_q.push_back({o_p1, o_p2, o_p3, o_p4});
                wgt_q.push_back({o_wx, o_wy});
            end
            if (o_rd_en) addr_q.push_back(32'(o_rd_addr));
            if (o_done) begin
                got_done = 1'b1;
                done_cyc = cyc;
                done_cnt++;
            end else begin
                if (cyc == inj) begin
                    i_start = 1'b1;
                    i_dst_w = 10'd1;
                    i_dst_h = 10'd1;
                end else begin
                    i_start = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        i_start = 1'b0;
        check("done_seen", 32'(got_done), 32'd1);
    endtask

    task automatic quiet(input int n, output int spurious);
        spurious = 0;
        repeat (n) begin
            @(negedge clk);
            if (o_done || o_start || o_rd_en) spurious++;
        end
    endtask

    // Reference mapping computed directly from dx*step, not incrementally.
    task automatic model_job(input int sw, input int sh, input int dw, input int dh, input int st);
        for (int y = 0; y < dh; y++) begin
            for (int x = 0; x < dw; x++) begin
                int ax, ay, xi, yi, x0, x1, y0, y1;
                logic [31:0] a00, a10, a01, a11;
                ax = x * st; ay = y * st;
                xi = ax >> 8; yi = ay >> 8;
                x0 = (xi     > sw - 1) ? sw - 1 : xi;
                x1 = (xi + 1 > sw - 1) ? sw - 1 : xi + 1;
                y0 = (yi     > sh - 1) ? sh - 1 : yi;
                y1 = (yi + 1 > sh - 1) ? sh - 1 : yi + 1;
                a00 = 32'(y0 * sw + x0);
                a10 = 32'(y0 * sw + x1);
                a01 = 32'(y1 * sw + x0);
                a11 = 32'(y1 * sw + x1);
                exp_addr_q.push_back(a00); exp_addr_q.push_back(a10);
                exp_addr_q.push_back(a01); exp_addr_q.push_back(a11);
                exp_smp_q.push_back({a00[7:0], a10[7:0], a01[7:0], a11[7:0]});
                exp_wgt_q.push_back({8'h00, 8'(ax & 255), 8'h00, 8'(ay & 255)});
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int sp;
        int cnt;
        int n;
        int done_a;
        rst_n = 1'b0; i_start = 1'b0;
        i_src_w = '0; i_src_h = '0; i_dst_w = '0; i_dst_h = '0; i_step = '0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Plain 2x: src 4x4 -> dst 2x2
        clear_logs();
        run_job(10'd4, 10'd4, 10'd2, 10'd2, 16'h0200, 60, -1);
        check("x2_count",  32'(smp_q.size()), 32'd4);
        check("x2_s0",     q_at(smp_q, 0), 32'h0001_0405);
        check("x2_s1",     q_at(smp_q, 1), 32'h0203_0607);
        check("x2_s2",     q_at(smp_q, 2), 32'h0809_0C0D);
        check("x2_s3",     q_at(smp_q, 3), 32'h0A0B_0E0F);
        check("x2_w0",     q_at(wgt_q, 0), 32'd0);
        check("x2_w3",     q_at(wgt_q, 3), 32'd0);
        check("x2_done",   32'(done_cyc), 32'd25);
        check("x2_reads",  32'(addr_q.size()), 32'd16);
        quiet(5, sp);
        check("x2_quiet",  32'(sp), 32'd0);

        // Fractional 1.5x with edge clamp: src 4x4 -> dst 3x3
        clear_logs();
        run_job(10'd4, 10'd4, 10'd3, 10'd3, 16'h0180, 100, -1);
        check("f_count",   32'(smp_q.size()), 32'd9);
        check("f_s1",      q_at(smp_q, 1), 32'h0102_0506);
        check("f_w1",      q_at(wgt_q, 1), 32'h0080_0000);
        check("f_s3",      q_at(smp_q, 3), 32'h0405_0809);
        check("f_w3",      q_at(wgt_q, 3), 32'h0000_0080);
        check("f_s8",      q_at(smp_q, 8), 32'h0F0F_0F0F);
        check("f_w8",      q_at(wgt_q, 8), 32'h0000_0000);
        check("f_done",    32'(done_cyc), 32'd55);

        // Zero-size job
        clear_logs();
        run_job(10'd4, 10'd4, 10'd0, 10'd3, 16'h0100, 10, -1);
        check("z_done",    32'(done_cyc), 32'd1);
        check("z_smp",     32'(smp_q.size()), 32'd0);
        check("z_reads",   32'(addr_q.size()), 32'd0);
        quiet(4, sp);
        check("z_quiet",   32'(sp), 32'd0);

        // Start while busy must be ignored
        clear_logs();
        run_job(10'd4, 10'd4, 10'd2, 10'd2, 16'h0200, 60, 7);
        quiet(10, sp);
        check("bz_count",  32'(smp_q.size()), 32'd4);
        check("bz_s0",     q_at(smp_q, 0), 32'h0001_0405);
        check("bz_s3",     q_at(smp_q, 3), 32'h0A0B_0E0F);
        check("bz_done",   32'(done_cyc), 32'd25);
        check("bz_ndone",  32'(done_cnt + sp), 32'd1);

        // Back-to-back: second start lands in the o_done cycle
        clear_logs();
        model_job(5, 3, 3, 2, 'h180);
        model_job(7, 5, 4, 3, 'h1C0);
        run_job(10'd5, 10'd3, 10'd3, 10'd2, 16'h0180, 80, -1);
        done_a = done_cyc;
        run_job(10'd7, 10'd5, 10'd4, 10'd3, 16'h01C0, 120, -1);
        check("bb_done_a", 32'(done_a), 32'd37);
        check("bb_done_b", 32'(done_cyc), 32'd73);
        check("bb_reads",  32'(addr_q.size()), 32'd72);
        check("bb_count",  32'(smp_q.size()), 32'd18);
        for (int i = 0; i < exp_addr_q.size(); i++)
            check($sformatf("bb_addr%0d", i), q_at(addr_q, i), exp_addr_q[i]);
        for (int i = 0; i < exp_smp_q.size(); i++) begin
            check($sformatf("bb_smp%0d", i), q_at(smp_q, i), exp_smp_q[i]);
            check($sformatf("bb_wgt%0d", i), q_at(wgt_q, i), exp_wgt_q[i]);
        end
        quiet(4, sp);

        // Reset in the middle of RD2 aborts the job without o_done
        i_src_w = 10'd4; i_src_h = 10'd4; i_dst_w = 10'd2; i_dst_h = 10'd2;
        i_step  = 16'h0200; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        cnt = 0; n = 0;
        while (cnt < 3 && n < 30) begin
            if (o_rd_en) cnt++;
            if (cnt < 3) begin
                @(negedge clk);
                n++;
            end
        end
        check("rst_reach_rd2", 32'(cnt), 32'd3);
        rst_n = 1'b0;
        @(negedge clk);
        chk_zero("midrst");
        quiet(2, sp);
        rst_n = 1'b1;
        quiet(8, n);
        check("midrst_quiet", 32'(sp + n), 32'd0);
        clear_logs();
        run_job(10'd4, 10'd4, 10'd2, 10'd2, 16'h0200, 60, -1);
        check("rr_count",  32'(smp_q.size()), 32'd4);
        check("rr_s0",     q_at(smp_q, 0), 32'h0001_0405);
        check("rr_s2",     q_at(smp_q, 2), 32'h0809_0C0D);
        check("rr_done",   32'(done_cyc), 32'd25);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bilinear_fetch_ctrl.md
# bilinear_fetch_ctrl

Upstream feeder for the bilinear interpolation pipeline. For each destination pixel of a downscale job it walks the output raster, maps the pixel to a source coordinate in fixed point, and reads the four neighbouring source pixels from a synchronous source RAM. It then presents one sample to the interpolation pipeline: the four pixels, the Q8.8 weights and a one-cycle start pulse. A job is started by a pulse and ends with a done pulse.

## Interface
- DIM_W, 10, width of the width/height fields (images up to 1023x1023)
- ADDR_W, 20, source RAM address width (must be ≥ 2*DIM_W)
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_start  in  1  job start pulse; accepted only in IDLE
- i_src_w, i_src_h  in  DIM_W each  source dimensions; latched at accepted start
- i_dst_w, i_dst_h  in  DIM_W each  destination dimensions; latched at accepted start
- i_step  in  16  source pixels per destination pixel, Q8.8 (0x0200 = 2x); latched at accepted start
- o_rd_en  out  1  source RAM read strobe
- o_rd_addr  out  ADDR_W  source RAM address = y*src_w + x
- i_rd_data  in  8  RAM data; valid in the cycle after o_rd_en
- o_p1, o_p2, o_p3, o_p4  out  8 each  neighbours (x0,y0), (x1,y0), (x0,y1), (x1,y1)
- o_wx, o_wy  out  16 each  weights, Q8.8, always {8'h00, frac}
- o_start  out  1  one-cycle strobe; o_p*/o_wx/o_wy are valid while it is high
- o_busy  out  1  job in progress
- o_done  out  1  one-cycle pulse after the last sample is emitted

## Operation
- States: IDLE, CALC, RD0, RD1, RD2, RD3, CAP.
- **IDLE.** On i_start, latch the configuration and clear dx, dy and the accumulators. If dst_w==0 or dst_h==0, pulse o_done next cycle and stay in IDLE. Otherwise go to CALC.
- **Accumulators.** acc_x and acc_y are DIM_W+16 bits, with 8 fractional bits.
  - acc_x = dx*step and acc_y = dy*step, maintained incrementally.
  - acc_x resets to 0 on row wrap.
- **CALC.** Compute the integer part xi = acc_x[top:8] and yi likewise.
  - x0 = min(xi, src_w-1); x1 = min(xi+1, src_w-1). y0 and y1 are computed the same way (edge replicate).
  - frac_x = acc_x[7:0], frac_y = acc_y[7:0].
  - Compute row bases y0*src_w and y1*src_w; the multiply is registered here.
- **RD0–RD3.** Issue one read per state, with o_rd_en=1, at addresses (x0,y0), (x1,y0), (x0,y1), (x1,y1).
- **Data capture.** p1 is captured at the end of RD1, p2 at the end of RD2, p3 at the end of RD3, p4 at the end of CAP.
- **End of CAP.**
  - Register o_start=1 together with the p/w outputs.
  - Advance dx; at dx==dst_w-1, wrap dx to 0 and advance dy.
  - If the pixel just processed was the last (dx==dst_w-1 and dy==dst_h-1), register o_done=1 and go to IDLE. Otherwise go to CALC.
- i_start is ignored while busy.
- Sample output order is row-major.
- Configuration inputs are don't-care outside the start cycle.
- The downstream pipeline never stalls, so there is no ready input.

## Timing
- **Reset values:** all outputs are 0 (o_p*, o_wx, o_wy, o_rd_addr, o_rd_en, o_start, o_busy, o_done). State is IDLE.
- **Reset mid-job:** aborts immediately. No o_done is produced.
- **Start latency:** with start accepted at edge T, CALC occupies cycle T..T+1, and the first o_rd_en is high in the following cycle.
- **Per-pixel cadence:** 6 cycles (CALC, RD0–RD3, CAP). o_start is high in the cycle after CAP, which coincides with the next CALC. o_start is therefore never asserted two cycles in a row.
- **Output hold:** o_p*, o_wx and o_wy are held until the next o_start.
- **o_busy:** high from the cycle after the accepted start through the cycle in which o_done is high; low otherwise.
- **Last sample:** o_done and the last o_start are asserted in the same cycle.
- **Total job length:** 6*dst_w*dst_h + 1 cycles from start to o_done.
- **Reads:** o_rd_en is high for exactly 4 cycles per pixel. o_rd_addr holds its value when o_rd_en is low.
- **Start during o_done:** a start arriving in the o_done cycle (state already IDLE) is accepted.

## Test plan
- **Reset:** assert rst_n=0 mid-RD2 -> all outputs 0 on the next sample point; no o_done; a new start then runs cleanly.
- **Plain 2x:** RAM mem[a]=a, src 4x4, dst 2x2, step 0x0200 -> 4 o_start pulses with (p1..p4) = (0,1,4,5), (2,3,6,7), (8,9,12,13), (10,11,14,15); all weights 0x0000; o_done 25 cycles after start.
- **Fractional 1.5x and edge clamp:** src 4x4, dst 3x3, step 0x0180.
  - Sample dx=1, dy=0 -> p=(1,2,5,6), wx=0x0080, wy=0.
  - Sample dx=2, dy=2 -> x0=x1=3, y0=y1=3, p=(15,15,15,15), wx=wy=0.
- **Zero-size job:** dst_w=0 -> o_done one cycle after start; no o_rd_en; no o_start.
- **Start while busy:** second i_start pulse mid-job -> ignored; the sample count and values match the first job; o_done once.
- **Back-to-back jobs:** i_start in the o_done cycle -> the second job starts. Across both jobs, read-address order matches the reference model exactly, and o_rd_en is high for exactly 4 cycles per pixel.
